// File: rtl/sd_spi_bridge_ctl.sv
// sd_spi_bridge_ctl
// Sits between the SPI master and the SD socket pad buffers. It debounces
// card detect and, before the SPI master gets the pins, runs the power-up
// clock burst with CS held high. It also synchronises MISO. Pad tri-state
// control is exposed as separate output and output-enable signals.
module sd_spi_bridge_ctl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int INIT_CLKS       = 80,
  parameter int INIT_DIV        = 128,
  parameter bit CD_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_spi_sck,
  input  logic [3:0] i_spi_dq_o,
  output logic [3:0] o_spi_dq_i,
  input  logic       i_spi_cs,
  input  logic       i_init_req,
  input  logic       i_sd_cd,
  output logic       o_sd_cmd_o,
  output logic       o_sd_cmd_oe,
  input  logic [3:0] i_sd_dat_i,
  output logic [3:0] o_sd_dat_o,
  output logic [3:0] o_sd_dat_oe,
  output logic       o_sd_sck,
  output logic       o_card_present,
  output logic       o_bridge_ready
);

  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W  = (INIT_DIV > 1) ? $clog2(INIT_DIV) : 1;
  localparam int EDGE_W = $clog2(INIT_CLKS + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_ZERO  = DEB_W'(0);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(INIT_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ZERO  = DIV_W'(0);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(INIT_CLKS);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
  localparam logic [EDGE_W-1:0] EDGE_ZERO = EDGE_W'(0);

  typedef enum logic [1:0] {
    ST_NO_CARD  = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_INIT_CLK = 2'd2,
    ST_READY    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DEB_W-1:0]     r_deb_cnt;
  logic [DEB_W-1:0]     w_deb_nxt;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [DIV_W-1:0]     w_div_nxt;
  logic [EDGE_W-1:0]    r_edge_cnt;
  logic [EDGE_W-1:0]    w_edge_nxt;
  logic                 r_sck;
  logic                 w_sck_nxt;
  logic                 r_pad_en;
  logic                 r_ready;
  logic                 r_present;
  logic [SYNC_STAGES-1:0] r_cd_sync;
  logic [SYNC_STAGES-1:0] r_miso_sync;
  logic                 w_cd_raw;
  logic                 w_cd_sync;
  logic                 w_miso_q;
  logic                 w_unused_bits;

  // The SPI master's upper data lanes and the card's upper DAT lanes do not
  // take part in 1-bit SPI mode.
  assign w_unused_bits = ^{i_spi_dq_o[3:1], i_sd_dat_i[3:1]};

  assign w_cd_raw  = CD_ACTIVE_LOW ? ~i_sd_cd : i_sd_cd;
  assign w_cd_sync = r_cd_sync[SYNC_STAGES-1];
  assign w_miso_q  = r_miso_sync[SYNC_STAGES-1];

  // Synchronise the asynchronous card-detect and MISO pins into clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cd_sync   <= {SYNC_STAGES{1'b0}};
      r_miso_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_cd_sync   <= {r_cd_sync[SYNC_STAGES-2:0], w_cd_raw};
      r_miso_sync <= {r_miso_sync[SYNC_STAGES-2:0], i_sd_dat_i[0]};
    end
  end

  // Next-state logic covers debounce counting, burst clock division and edge counting.
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb_cnt;
    w_div_nxt   = r_div_cnt;
    w_edge_nxt  = r_edge_cnt;
    w_sck_nxt   = 1'b0;
    case (r_state)
      ST_NO_CARD: begin
        w_deb_nxt  = DEB_ZERO;
        w_div_nxt  = DIV_ZERO;
        w_edge_nxt = EDGE_ZERO;
        if (w_cd_sync) begin
          w_state_nxt = ST_DEBOUNCE;
        end else begin
          w_state_nxt = ST_NO_CARD;
        end
      end
      ST_DEBOUNCE: begin
        if (!w_cd_sync) begin
          w_state_nxt = ST_NO_CARD;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt = ST_INIT_CLK;
          w_div_nxt   = DIV_ZERO;
          w_edge_nxt  = EDGE_ZERO;
        end else begin
          w_deb_nxt = r_deb_cnt + DEB_ONE;
        end
      end
      ST_INIT_CLK: begin
        if (!w_cd_sync) begin
          w_state_nxt = ST_NO_CARD;
        end else if (r_div_cnt == DIV_LAST) begin
          w_div_nxt = DIV_ZERO;
          if (r_sck) begin
            // A falling wrap after the final rising edge ends the burst with SCK low.
            w_sck_nxt = 1'b0;
            if (r_edge_cnt == EDGE_LAST) begin
              w_state_nxt = ST_READY;
            end else begin
              w_state_nxt = ST_INIT_CLK;
            end
          end else begin
            w_sck_nxt  = 1'b1;
            w_edge_nxt = r_edge_cnt + EDGE_ONE;
          end
        end else begin
          w_div_nxt = r_div_cnt + DIV_ONE;
          w_sck_nxt = r_sck;
        end
      end
      ST_READY: begin
        // Card removal takes priority over a re-init request.
        if (!w_cd_sync) begin
          w_state_nxt = ST_NO_CARD;
        end else if (i_init_req) begin
          w_state_nxt = ST_INIT_CLK;
          w_div_nxt   = DIV_ZERO;
          w_edge_nxt  = EDGE_ZERO;
        end else begin
          w_state_nxt = ST_READY;
        end
      end
      default: begin
        w_state_nxt = ST_NO_CARD;
      end
    endcase
  end

  // State, counters, burst clock and the decoded status/pad-enable registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_NO_CARD;
      r_deb_cnt  <= DEB_ZERO;
      r_div_cnt  <= DIV_ZERO;
      r_edge_cnt <= EDGE_ZERO;
      r_sck      <= 1'b0;
      r_pad_en   <= 1'b0;
      r_ready    <= 1'b0;
      r_present  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_deb_cnt  <= w_deb_nxt;
      r_div_cnt  <= w_div_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_sck      <= w_sck_nxt;
      r_pad_en   <= (w_state_nxt != ST_NO_CARD);
      r_ready    <= (w_state_nxt == ST_READY);
      r_present  <= (w_state_nxt == ST_INIT_CLK) || (w_state_nxt == ST_READY);
    end
  end

  // In READY the SPI master drives the card directly. Before that, CS and CMD
  // idle high, and SCK is either the burst clock or low.
  assign o_sd_sck       = r_ready ? i_spi_sck : r_sck;
  assign o_sd_cmd_o     = r_ready ? i_spi_dq_o[0] : 1'b1;
  assign o_sd_cmd_oe    = r_pad_en;
  assign o_sd_dat_o     = {(r_ready ? i_spi_cs : 1'b1), 3'b000};
  assign o_sd_dat_oe    = {r_pad_en, 3'b000};
  assign o_spi_dq_i     = {2'b00, (r_ready ? w_miso_q : 1'b1), 1'b0};
  assign o_card_present = r_present;
  assign o_bridge_ready = r_ready;

endmodule

// File: tb/tb_sd_spi_bridge_ctl.sv
// Randomised bench for sd_spi_bridge_ctl. A reference model tracks the phase
// (no card / debounce / burst / ready) and the time spent in it. Every output
// is predicted from that phase and time plus the live inputs.
module tb_sd_spi_bridge_ctl;

  localparam int SYNC      = 2;
  localparam int DEB       = 16;
  localparam int ICLK      = 8;
  localparam int IDIV      = 4;
  localparam int BURST_LEN = 2 * ICLK * IDIV;

  localparam int PH_NONE  = 0;
  localparam int PH_DEB   = 1;
  localparam int PH_BURST = 2;
  localparam int PH_READY = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_spi_sck = 1'b0;
  logic [3:0] i_spi_dq_o = 4'd0;
  logic [3:0] o_spi_dq_i;
  logic       i_spi_cs = 1'b1;
  logic       i_init_req = 1'b0;
  logic       i_sd_cd = 1'b1;
  logic       o_sd_cmd_o;
  logic       o_sd_cmd_oe;
  logic [3:0] i_sd_dat_i = 4'd0;
  logic [3:0] o_sd_dat_o;
  logic [3:0] o_sd_dat_oe;
  logic       o_sd_sck;
  logic       o_card_present;
  logic       o_bridge_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int         m_ph = PH_NONE;
  int         m_old_ph = PH_NONE;
  int         m_t = 0;
  logic [1:0] m_cd = 2'b00;
  logic [1:0] m_miso = 2'b00;
  int         edge_cnt = 0;
  logic       prev_sck = 1'b0;

  sd_spi_bridge_ctl #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .INIT_CLKS(ICLK),
    .INIT_DIV(IDIV), .CD_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .i_spi_sck(i_spi_sck), .i_spi_dq_o(i_spi_dq_o), .o_spi_dq_i(o_spi_dq_i),
    .i_spi_cs(i_spi_cs), .i_init_req(i_init_req), .i_sd_cd(i_sd_cd),
    .o_sd_cmd_o(o_sd_cmd_o), .o_sd_cmd_oe(o_sd_cmd_oe),
    .i_sd_dat_i(i_sd_dat_i), .o_sd_dat_o(o_sd_dat_o), .o_sd_dat_oe(o_sd_dat_oe),
    .o_sd_sck(o_sd_sck), .o_card_present(o_card_present), .o_bridge_ready(o_bridge_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    logic cd_s;
    cd_s = m_cd[1];
    m_old_ph = m_ph;
    if (reset) begin
      m_ph = PH_NONE; m_t = 0; m_cd = 2'b00; m_miso = 2'b00;
    end else begin
      if (m_ph != PH_NONE && !cd_s) begin
        m_ph = PH_NONE; m_t = 0;
      end else begin
        case (m_ph)
          PH_NONE:  if (cd_s) begin m_ph = PH_DEB; m_t = 0; end
          PH_DEB:   begin m_t++; if (m_t == DEB) begin m_ph = PH_BURST; m_t = 0; end end
          PH_BURST: begin m_t++; if (m_t == BURST_LEN) begin m_ph = PH_READY; m_t = 0; end end
          PH_READY: if (i_init_req) begin m_ph = PH_BURST; m_t = 0; end
          default:  m_ph = PH_NONE;
        endcase
      end
      m_cd   = {m_cd[0], ~i_sd_cd};
      m_miso = {m_miso[0], i_sd_dat_i[0]};
    end
  endtask

  task automatic check_outputs(input string where);
    logic ready, pad, present, exp_sck;
    ready   = (m_ph == PH_READY);
    pad     = (m_ph != PH_NONE);
    present = (m_ph == PH_BURST) || (m_ph == PH_READY);
    if (ready) exp_sck = i_spi_sck;
    else if (m_ph == PH_BURST) exp_sck = (((m_t / IDIV) % 2) == 1);
    else exp_sck = 1'b0;
    chk({where, ":sd_sck"}, 32'(o_sd_sck), 32'(exp_sck));
    chk({where, ":cmd"}, 32'({o_sd_cmd_o, o_sd_cmd_oe}),
        32'({(ready ? i_spi_dq_o[0] : 1'b1), pad}));
    chk({where, ":dat"}, 32'({o_sd_dat_o, o_sd_dat_oe}),
        32'({(ready ? i_spi_cs : 1'b1), 3'b000, pad, 3'b000}));
    chk({where, ":dq_i"}, 32'(o_spi_dq_i), 32'({2'b00, (ready ? m_miso[1] : 1'b1), 1'b0}));
    chk({where, ":status"}, 32'({o_card_present, o_bridge_ready}), 32'({present, ready}));
  endtask

  // One clock cycle: new inputs at negedge, combinational check, edge, registered check.
  task automatic step(input logic rst, input logic cd_n, input logic ireq);
    @(negedge clk);
    reset      = rst;
    i_sd_cd    = cd_n;
    i_init_req = ireq;
    i_spi_sck  = 1'($urandom);
    i_spi_dq_o = 4'($urandom);
    i_spi_cs   = 1'($urandom);
    i_sd_dat_i = 4'($urandom);
    #1 check_outputs("mid");
    @(posedge clk);
    model_edge();
    #1 check_outputs("edge");
    if (m_ph == PH_BURST && m_old_ph != PH_BURST) edge_cnt = 0;
    else if (m_ph == PH_BURST && !prev_sck && o_sd_sck) edge_cnt++;
    if (m_old_ph == PH_BURST && m_ph == PH_READY) chk("burst_edges", 32'(edge_cnt), 32'(ICLK));
    prev_sck = o_sd_sck;
  endtask

  task automatic check_reset_values(input string tag);
    chk(tag, 32'({o_spi_dq_i, o_sd_cmd_o, o_sd_cmd_oe, o_sd_dat_o, o_sd_dat_oe,
                  o_sd_sck, o_card_present, o_bridge_ready}),
        32'({4'b0010, 1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0}));
  endtask

  // Hold the card inserted and count cycles until the DUT reports ready.
  task automatic steps_to_ready(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end while (!o_bridge_ready && n < 400);
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    int n;
    int gap;

    repeat (3) step(1'b1, 1'b1, 1'b0);
    check_reset_values("reset_values");

    // Insertion: two sync flops, one cycle to leave NO_CARD, DEB in debounce, then the burst.
    steps_to_ready("insert_to_ready", SYNC + 1 + DEB + BURST_LEN);

    // READY passthrough with random SPI/MISO traffic.
    repeat (40) step(1'b0, 1'b0, 1'b0);

    // Re-init from READY.
    step(1'b0, 1'b0, 1'b1);
    chk("ireq_drops_ready", 32'(o_bridge_ready), 32'd0);
    steps_to_ready("reinit_to_ready", BURST_LEN);

    // Remove the card, then re-insert it and pulse init_req during debounce (it must be ignored).
    repeat (5) step(1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Bounce: 10 low, 1 high, then low. After the glitch the synced presence
    // is low for one cycle (leave to NO_CARD), then 1 cycle re-entry and 16 debounce.
    repeat (5) step(1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end while (!o_card_present && n < 100);
    chk("bounce_restart", 32'(n), 32'(SYNC + 1 + 1 + DEB - 1));
    steps_to_ready("bounce_to_ready", BURST_LEN);

    // Removal mid-burst at the third SCK rising edge.
    step(1'b0, 1'b0, 1'b1);
    n = 0;
    while (!(m_ph == PH_BURST && edge_cnt == 3) && n < 100) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("reach_third_edge", 32'(edge_cnt), 32'd3);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    chk("removed_state", 32'({o_card_present, o_bridge_ready, o_sd_cmd_oe, o_sd_dat_oe, o_sd_sck}),
        32'd0);

    // Reset in the middle of a burst, then the full insertion sequence again.
    repeat (SYNC + 1 + DEB + 10) step(1'b0, 1'b0, 1'b0);
    chk("in_burst_before_reset", 32'({o_card_present, o_bridge_ready}), 32'b10);
    step(1'b1, 1'b0, 1'b0);
    check_reset_values("reset_mid_burst");
    steps_to_ready("reinsert_to_ready", SYNC + 1 + DEB + BURST_LEN);

    // Random soak: removal glitches of random length, init pulses, rare resets.
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      if (gap > 0) gap--;
      else if ($urandom_range(0, 149) == 0) gap = int'($urandom_range(1, 25));
      step(($urandom_range(0, 599) == 0), (gap > 0), ($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
